// File: rtl/zmips_pkg.sv
// zmips_pkg: constants shared by the zmips core. It holds the default datapath
// width, the canonical no-op word and the major opcode encodings.
package zmips_pkg;

    localparam int          ZM_XLEN = 32;

    // An all-zero word decodes as "sll r0, r0, 0", which is the canonical MIPS no-op.
    localparam logic [31:0] I_NOP    = 32'h0000_0000;
    localparam logic [31:0] NOP_WORD = I_NOP;

    typedef enum logic [5:0] {
        OP_RTYPE = 6'h00,
        OP_J     = 6'h02,
        OP_JAL   = 6'h03,
        OP_BEQ   = 6'h04,
        OP_BNE   = 6'h05,
        OP_ADDI  = 6'h08,
        OP_LW    = 6'h23,
        OP_SW    = 6'h2B
    } zmips_opcode_t;

endpackage

// File: rtl/zmips_sync_fifo.sv
// zmips_sync_fifo: prefetch queue. State changes on the falling clock edge.
//   clk, rst      : clock (falling-edge active); asynchronous active-high reset
//   push / wdata  : write an entry (ignored when full or flushing)
//   pop           : remove the head entry (ignored when empty)
//   flush         : empty the queue; wins over a same-cycle push
//   rdata         : head entry (valid only when empty=0)
//   full, empty, count : occupancy status
module zmips_sync_fifo
    import zmips_pkg::*;
#(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic                       pop,
    input  logic                       flush,
    input  logic [WIDTH-1:0]           wdata,
    output logic [WIDTH-1:0]           rdata,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full && !flush;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    // DEPTH is a power of two, so the pointers wrap on their own.
    always_ff @(negedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    // Storage is data only and carries no reset.
    always_ff @(negedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/zmips_fetch_unit.sv
// zmips_fetch_unit: instruction fetch stage. It has a PC generator, a pipelined
// request/response instruction-memory port and a DEPTH-entry prefetch queue
// that feeds ID. State changes on the falling clock edge.
//   clk, rst              : clock (falling-edge active); asynchronous active-high reset
//   i_req/i_addr/i_gnt    : fetch request handshake to instruction memory
//   i_rvalid/i_rdata      : in-order instruction responses
//   redir_valid/redir_pc  : taken branch/jump from ID/EX; flushes stale work
//   id_valid/id_ready     : handshake with ID for the head entry
//   id_ir/id_pc           : head instruction and its address + 4
module zmips_fetch_unit
    import zmips_pkg::*;
#(
    parameter int              XLEN     = ZM_XLEN,
    parameter int              DEPTH    = 4,
    parameter int              MAX_OUT  = 2,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter logic [XLEN-1:0] NOP_WORD = XLEN'(I_NOP)
) (
    input  logic            clk,
    input  logic            rst,
    output logic            i_req,
    output logic [XLEN-1:0] i_addr,
    input  logic            i_gnt,
    input  logic            i_rvalid,
    input  logic [XLEN-1:0] i_rdata,
    input  logic            redir_valid,
    input  logic [XLEN-1:0] redir_pc,
    input  logic            id_ready,
    output logic            id_valid,
    output logic [XLEN-1:0] id_ir,
    output logic [XLEN-1:0] id_pc
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int OUT_W = $clog2(MAX_OUT + 1);
    localparam int SUM_W = ((CNT_W > OUT_W) ? CNT_W : OUT_W) + 1;

    logic [XLEN-1:0]   fetch_pc;
    logic [XLEN-1:0]   resp_pc;
    logic [OUT_W-1:0]  outstanding;
    logic [OUT_W-1:0]  discard;

    logic [CNT_W-1:0]  q_count;
    logic              q_full;
    logic              q_empty;
    logic [2*XLEN-1:0] q_head;
    logic              q_push;
    logic              q_pop;

    logic [XLEN-1:0]   redir_tgt;
    logic [SUM_W-1:0]  in_flight;
    logic              grant;
    logic              keep;
    logic              drop;

    // Reserving a queue slot for every outstanding request means a response
    // always has room when it lands.
    assign in_flight = SUM_W'(q_count) + SUM_W'(outstanding);
    assign i_req     = !rst && !redir_valid
                       && (outstanding < OUT_W'(MAX_OUT))
                       && (in_flight < SUM_W'(DEPTH));
    assign i_addr    = fetch_pc;
    assign grant     = i_req && i_gnt;

    assign redir_tgt = redir_pc & ~XLEN'(3);
    assign keep      = i_rvalid && (discard == '0) && !redir_valid;
    assign drop      = i_rvalid && (discard != '0);

    assign q_push    = keep;
    assign q_pop     = id_ready && !q_empty;

    assign id_valid  = !q_empty;
    assign id_ir     = q_empty ? NOP_WORD : q_head[2*XLEN-1:XLEN];
    // With an empty queue, show the address after the next expected instruction.
    assign id_pc     = q_empty ? (resp_pc + XLEN'(4)) : q_head[XLEN-1:0];

    always_ff @(negedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc    <= RESET_PC;
            resp_pc     <= RESET_PC;
            outstanding <= '0;
            discard     <= '0;
        end else begin
            outstanding <= outstanding + OUT_W'(grant) - OUT_W'(i_rvalid);
            if (redir_valid) begin
                fetch_pc <= redir_tgt;
                resp_pc  <= redir_tgt;
                // No grant happens in a redirect cycle, so everything still in
                // flight after this edge is stale and must be dropped.
                discard  <= outstanding - OUT_W'(i_rvalid);
            end else begin
                if (grant) fetch_pc <= fetch_pc + XLEN'(4);
                if (keep)  resp_pc  <= resp_pc + XLEN'(4);
                if (drop)  discard  <= discard - OUT_W'(1);
            end
        end
    end

    zmips_sync_fifo #(
        .WIDTH (2 * XLEN),
        .DEPTH (DEPTH)
    ) u_queue (
        .clk   (clk),
        .rst   (rst),
        .push  (q_push),
        .pop   (q_pop),
        .flush (redir_valid),
        .wdata ({i_rdata, resp_pc + XLEN'(4)}),
        .rdata (q_head),
        .full  (q_full),
        .empty (q_empty),
        .count (q_count)
    );

    a_rvalid_owed:  assert property (@(negedge clk) disable iff (rst) !(i_rvalid && outstanding == '0));
    a_no_overflow:  assert property (@(negedge clk) disable iff (rst) !(q_push && q_full));
    a_count_bound:  assert property (@(negedge clk) disable iff (rst) q_count <= CNT_W'(DEPTH));
    a_out_bound:    assert property (@(negedge clk) disable iff (rst) outstanding <= OUT_W'(MAX_OUT));
    a_discard_le:   assert property (@(negedge clk) disable iff (rst) discard <= outstanding);

endmodule
